exp_series_datapath: RTL and testbench

- Fixed-point datapath that evaluates e^x as a truncated Taylor series: sum over n of x^n/n!.
- Driven by the existing sequencing controller through load_a, load_sel and done; returns is_finished to that controller.
- Holds the input operand, the current term, the accumulator and the term counter.
- Latches the final sum into a result register when the controller signals done.

---
 rtl/exp_series_datapath_pkg.sv | 46 ++++
 rtl/exp_series_datapath_term_mul_coef.sv | 29 ++
 rtl/exp_series_datapath.sv | 108 ++++++++++
 tb/tb_exp_series_datapath.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/exp_series_datapath_pkg.sv
// Shared constants for the e^x Taylor-series datapath: fixed-point widths,
// the 1/n coefficient table and the sequencing controller's state codes.
package exp_series_datapath_pkg;

  localparam int FRAC    = 16;        // fractional bits of x, term, coef, acc
  localparam int X_W     = 16;        // x operand, Q0.16
  localparam int TERM_W  = 17;        // series term, Q1.16 (value <= 1.0)
  localparam int COEF_W  = 17;        // 1/n coefficient, Q1.16 (1/1 needs bit 16)
  localparam int ACC_W   = 18;        // accumulator / result, Q2.16
  localparam int CNT_W   = 4;         // term counter
  localparam int IDX_W   = 5;         // coefficient index 1..16
  localparam int ONE_Q   = 65536;     // 1.0 in Q.16
  localparam int N_TERMS = 5;         // default number of series terms

  // Sequencing controller state encodings.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_INIT   = 3'd1;
  localparam logic [2:0] ST_ADD    = 3'd2;
  localparam logic [2:0] ST_WB_ACT = 3'd3;
  localparam logic [2:0] ST_CHECK  = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;

  // floor(65536 / n) for n = 1..16; a constant table rather than a divider.
  function automatic logic [COEF_W-1:0] coef_lut(input logic [IDX_W-1:0] n);
    case (n)
      5'd1:    coef_lut = 17'd65536;
      5'd2:    coef_lut = 17'd32768;
      5'd3:    coef_lut = 17'd21845;
      5'd4:    coef_lut = 17'd16384;
      5'd5:    coef_lut = 17'd13107;
      5'd6:    coef_lut = 17'd10922;
      5'd7:    coef_lut = 17'd9362;
      5'd8:    coef_lut = 17'd8192;
      5'd9:    coef_lut = 17'd7281;
      5'd10:   coef_lut = 17'd6553;
      5'd11:   coef_lut = 17'd5957;
      5'd12:   coef_lut = 17'd5461;
      5'd13:   coef_lut = 17'd5041;
      5'd14:   coef_lut = 17'd4681;
      5'd15:   coef_lut = 17'd4369;
      5'd16:   coef_lut = 17'd4096;
      default: coef_lut = '0;
    endcase
  endfunction

endpackage

// File: rtl/exp_series_datapath_term_mul_coef.sv
// Combinational next-term path: nt = ((term * x) >> FRAC) * COEF[idx] >> FRAC.
// Both shifts floor and both results are truncated to the term width.
module exp_series_datapath_term_mul_coef
  import exp_series_datapath_pkg::*;
#(
  parameter int XW = X_W,
  parameter int FB = FRAC
) (
  input  logic [TERM_W-1:0] term_i,
  input  logic [XW-1:0]     x_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [TERM_W-1:0] nt_o
);

  localparam int P1_W = TERM_W + XW;      // term * x, 33 bits
  localparam int P2_W = TERM_W + COEF_W;  // p1 * coef, 34 bits

  logic [P1_W-1:0]   prod1;
  logic [TERM_W-1:0] p1;
  logic [COEF_W-1:0] coef;
  logic [P2_W-1:0]   prod2;

  assign prod1 = P1_W'(term_i) * P1_W'(x_i);
  assign p1    = TERM_W'(prod1 >> FB);
  assign coef  = coef_lut(idx_i);
  assign prod2 = P2_W'(p1) * P2_W'(coef);
  assign nt_o  = TERM_W'(prod2 >> FB);

endmodule

// File: rtl/exp_series_datapath.sv
// e^x Taylor-series datapath: holds x, the current term, the accumulator and
// the term counter, and captures the finished sum when the controller says done.
module exp_series_datapath
  import exp_series_datapath_pkg::*;
#(
  parameter int X_W     = exp_series_datapath_pkg::X_W,
  parameter int FRAC    = exp_series_datapath_pkg::FRAC,
  parameter int N_TERMS = exp_series_datapath_pkg::N_TERMS,
  parameter int ACC_W   = exp_series_datapath_pkg::ACC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [X_W-1:0]   x_in,
  input  logic             load_a,
  input  logic             load_sel,
  input  logic             done,
  output logic             is_finished,
  output logic [ACC_W-1:0] result,
  output logic             result_valid
);

  logic [X_W-1:0]    x_q,      x_d;
  logic [TERM_W-1:0] term_q,   term_d;
  logic [ACC_W-1:0]  acc_q,    acc_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ACC_W-1:0]  result_q, result_d;
  logic              valid_q,  valid_d;

  logic [TERM_W-1:0] nt;
  logic [IDX_W-1:0]  coef_idx;
  logic              do_init;
  logic              do_wb;

  // Writeback n uses coefficient 1/(cnt+1).
  assign coef_idx = IDX_W'(cnt_q) + IDX_W'(1);

  exp_series_datapath_term_mul_coef #(
    .XW (X_W),
    .FB (FRAC)
  ) u_term_mul_coef (
    .term_i (term_q),
    .x_i    (x_q),
    .idx_i  (coef_idx),
    .nt_o   (nt)
  );

  // Counter saturates at the last term; a late writeback is ignored.
  assign is_finished = (cnt_q == CNT_W'(N_TERMS - 1));
  assign do_init     = load_a && load_sel;
  assign do_wb       = load_a && !load_sel && !is_finished;

  // Next-state selection for the operand/term/accumulator and result capture.
  always_comb begin
    // NOTE: every target gets a hold default first so no path infers a latch.
    x_d      = x_q;
    term_d   = term_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    valid_d  = valid_q;

    if (do_init) begin
      x_d    = x_in;
      term_d = TERM_W'(ONE_Q);
      acc_d  = ACC_W'(ONE_Q);
      cnt_d  = '0;
    end else if (do_wb) begin
      term_d = nt;
      acc_d  = acc_q + ACC_W'(nt);
      cnt_d  = cnt_q + CNT_W'(1);
    end

    // done captures the pre-update accumulator; a coincident init still
    // clears the valid flag because the new evaluation supersedes it.
    if (done) begin
      result_d = acc_q;
      valid_d  = 1'b1;
    end
    if (do_init) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset shared with the controller.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample the same pre-edge values.
    if (rst) begin
      x_q      <= '0;
      term_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      term_q   <= term_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;

endmodule

// File: tb/tb_exp_series_datapath.sv
// Self-checking bench for exp_series_datapath: directed cases for the key
// series values, then randomized evaluations driven like the controller.
module tb_exp_series_datapath;
  import exp_series_datapath_pkg::*;

  localparam int N  = 5;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   x_in;
  logic          load_a;
  logic          load_sel;
  logic          done;
  logic          is_finished;
  logic [AW-1:0] result;
  logic          result_valid;

  int n_checks = 0;
  int n_errors = 0;

  exp_series_datapath #(
    .X_W     (16),
    .FRAC    (16),
    .N_TERMS (N),
    .ACC_W   (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .x_in         (x_in),
    .load_a       (load_a),
    .load_sel     (load_sel),
    .done         (done),
    .is_finished  (is_finished),
    .result       (result),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Series sum after k writebacks: 1 + sum of terms, each term being the
  // previous one times x, divided by n, with floor at every Q.16 step.
  function automatic longint model_acc(input longint x, input int k);
    longint term = 65536;
    longint acc  = 65536;
    int kk = (k > N - 1) ? N - 1 : k;
    for (int n = 1; n <= kk; n++) begin
      term = ((((term * x) >> 16) & 'h1FFFF) * (65536 / n)) >> 16;
      term = term & 'h1FFFF;
      acc  = acc + term;
    end
    return acc;
  endfunction

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_init(input logic [15:0] x);
    x_in = x; load_a = 1'b1; load_sel = 1'b1;
    step();
    load_a = 1'b0; load_sel = 1'b0;
  endtask

  task automatic do_wb();
    load_a = 1'b1; load_sel = 1'b0;
    step();
    load_a = 1'b0;
  endtask

  task automatic do_done();
    done = 1'b1;
    step();
    done = 1'b0;
  endtask

  // Directed evaluation: after each writeback, probe acc through done.
  task automatic run_series(input string name, input logic [15:0] x);
    do_init(x);
    for (int k = 1; k <= N - 1; k++) begin
      do_wb();
      check($sformatf("%s_fin_wb%0d", name, k), 64'(is_finished), 64'(k == N - 1));
      do_done();
      check($sformatf("%s_acc_wb%0d", name, k), 64'(result), 64'(model_acc(x, k)));
    end
    check({name, "_valid"}, 64'(result_valid), 64'd1);
  endtask

  logic [2:0]  st;
  logic [15:0] rx;
  int          wb_cnt;
  int          init_hold;
  bit          finished_run;
  logic [AW-1:0] saved;

  initial begin
    rst = 1'b1; x_in = '0; load_a = 1'b0; load_sel = 1'b0; done = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_fin", 64'(is_finished), 64'd0);

    // Reset in mid-evaluation after two writebacks.
    do_init(16'h8000);
    do_wb(); do_wb();
    rst = 1'b1; step(); rst = 1'b0;
    check("mid_rst_fin", 64'(is_finished), 64'd0);
    check("mid_rst_valid", 64'(result_valid), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    do_done();
    check("mid_rst_acc", 64'(result), 64'd0);
    for (int k = 1; k <= N - 1; k++) begin
      do_wb();
      check($sformatf("mid_rst_cnt_wb%0d", k), 64'(is_finished), 64'(k == N - 1));
    end

    // x = 0: every term after the first is zero.
    run_series("x0", 16'h0000);
    check("x0_result", 64'(result), 64'd65536);

    // x = 0.5 and x = max, with the known final sums.
    run_series("xhalf", 16'h8000);
    check("xhalf_result", 64'(result), 64'd108031);
    run_series("xmax", 16'hFFFF);
    check("xmax_result", 64'(result), 64'd177489);

    // Protocol violation: extra writeback at the last term holds state.
    do_wb();
    check("extra_wb_fin", 64'(is_finished), 64'd1);
    do_done();
    check("extra_wb_acc", 64'(result), 64'd177489);

    // Back-to-back: init held 3 cycles clears valid, keeps the old result.
    saved = result;
    x_in = 16'h1234; load_a = 1'b1; load_sel = 1'b1;
    step();
    check("b2b_valid_clr", 64'(result_valid), 64'd0);
    check("b2b_result_keep1", 64'(result), 64'(saved));
    step(); step();
    load_a = 1'b0; load_sel = 1'b0;
    check("b2b_result_keep3", 64'(result), 64'(saved));
    check("b2b_fin_clr", 64'(is_finished), 64'd0);

    // done together with init: result takes the old acc, init clears valid.
    do_wb();
    done = 1'b1; load_a = 1'b1; load_sel = 1'b1;
    step();
    done = 1'b0; load_a = 1'b0; load_sel = 1'b0;
    check("done_init_valid", 64'(result_valid), 64'd0);
    check("done_init_result", 64'(result), 64'(model_acc(16'h1234, 1)));
    do_done();
    check("after_init_acc", 64'(result), 64'd65536);
    check("after_init_valid", 64'(result_valid), 64'd1);

    // Randomized evaluations sequenced like the controller.
    for (int it = 0; it < 25; it++) begin
      rx = 16'($urandom);
      if (it == 0) rx = 16'hFFFF;
      st = ST_IDLE;
      wb_cnt = 0;
      finished_run = 1'b0;
      for (int cyc = 0; cyc < 60 && !finished_run; cyc++) begin
        case (st)
          ST_IDLE: begin
            step();
            st = ST_INIT;
          end
          ST_INIT: begin
            init_hold = $urandom_range(1, 3);
            x_in = rx; load_a = 1'b1; load_sel = 1'b1;
            repeat (init_hold) step();
            load_a = 1'b0; load_sel = 1'b0;
            check("rnd_init_valid", 64'(result_valid), 64'd0);
            st = ST_ADD;
          end
          ST_ADD: begin
            step();
            st = ST_WB_ACT;
          end
          ST_WB_ACT: begin
            do_wb();
            wb_cnt++;
            st = ST_CHECK;
          end
          ST_CHECK: begin
            check($sformatf("rnd%0d_fin_wb%0d", it, wb_cnt), 64'(is_finished),
                  64'(wb_cnt == N - 1));
            step();
            st = (wb_cnt >= N - 1) ? ST_DONE : ST_ADD;
          end
          ST_DONE: begin
            do_done();
            check($sformatf("rnd%0d_result_x%0h", it, rx), 64'(result),
                  64'(model_acc(64'(rx), N - 1)));
            check($sformatf("rnd%0d_valid", it), 64'(result_valid), 64'd1);
            finished_run = 1'b1;
          end
          default: st = ST_IDLE;
        endcase
      end
      if (!finished_run) check($sformatf("rnd%0d_timeout", it), 64'd0, 64'd1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
